// File: rtl/data_buffer_arbiter_if.sv
// rtl/data_buffer_arbiter_if.sv - request, read-return and RAM bus bundle for data_buffer_arbiter
//   clear                          flush pulse from the AHB register block
//   ahb_store/ahb_get/ahb_wdata    AHB byte requests, held until ahb_grant
//   usb_store/usb_get/usb_wdata    USB RX/TX byte requests, held until usb_grant
//   ahb_grant/usb_grant            combinational grant in the request cycle
//   rd_data/ahb_rvalid/usb_rvalid  read byte and its owner, one cycle after grant
//   mem_we/mem_re/mem_addr/
//   mem_wdata/mem_rdata            single-port RAM, one cycle read latency
//   buffer_occupancy               bytes held, 0..DEPTH
//   overflow_err/underflow_err     sticky error flags
//   master: requesters and RAM; slave: the arbiter
interface data_buffer_arbiter_if #(
  parameter int PTR_W = 6
);
  logic             clear;
  logic             ahb_store;
  logic             ahb_get;
  logic [7:0]       ahb_wdata;
  logic             usb_store;
  logic             usb_get;
  logic [7:0]       usb_wdata;
  logic [7:0]       mem_rdata;
  logic             ahb_grant;
  logic             usb_grant;
  logic [7:0]       rd_data;
  logic             ahb_rvalid;
  logic             usb_rvalid;
  logic             mem_we;
  logic             mem_re;
  logic [PTR_W-1:0] mem_addr;
  logic [7:0]       mem_wdata;
  logic [PTR_W:0]   buffer_occupancy;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output clear, ahb_store, ahb_get, ahb_wdata, usb_store, usb_get, usb_wdata, mem_rdata,
    input  ahb_grant, usb_grant, rd_data, ahb_rvalid, usb_rvalid,
    input  mem_we, mem_re, mem_addr, mem_wdata, buffer_occupancy, overflow_err, underflow_err
  );

  modport slave (
    input  clear, ahb_store, ahb_get, ahb_wdata, usb_store, usb_get, usb_wdata, mem_rdata,
    output ahb_grant, usb_grant, rd_data, ahb_rvalid, usb_rvalid,
    output mem_we, mem_re, mem_addr, mem_wdata, buffer_occupancy, overflow_err, underflow_err
  );
endinterface

// File: rtl/data_buffer_arbiter.sv
// rtl/data_buffer_arbiter.sv - 64-byte endpoint buffer owner and AHB/USB access arbiter
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   io_bus  data_buffer_arbiter_if.slave (requests, grants, read return, RAM port, status)
//   RR_ARB_EN  defined: round-robin between contending sides with symmetric wait counters;
//              undefined: fixed USB priority with MAX_WAIT starvation override for AHB
module data_buffer_arbiter #(
  parameter int DEPTH    = 64,
  parameter int PTR_W    = 6,
  parameter int MAX_WAIT = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  data_buffer_arbiter_if.slave io_bus
);
  localparam int               WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [PTR_W:0]   OCC_FULL   = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_USB_ACC = 2'd1;
  localparam logic [1:0] S_AHB_ACC = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_occ;
  logic [WAIT_W-1:0] r_ahb_wait;
`ifdef RR_ARB_EN
  logic [WAIT_W-1:0] r_usb_wait;
  logic              r_last_usb;  // 1: USB won the most recent contested cycle
`endif
  logic              r_got;          // previous cycle's access was a get
  logic              r_rd_from_ram;  // previous get actually read the RAM
  logic [7:0]        r_rd_hold;
  logic              r_ovf;
  logic              r_unf;

  logic       w_ahb_req;
  logic       w_usb_req;
  logic       w_ahb_prio;
  logic       w_usb_win;
  logic       w_ahb_win;
  logic       w_store;
  logic       w_get;
  logic       w_full;
  logic       w_empty;
  logic       w_we;
  logic       w_re;
  logic [7:0] w_wdata;
  logic [1:0] w_state_nxt;

  always_comb begin
    w_ahb_req = io_bus.ahb_store | io_bus.ahb_get;
    w_usb_req = io_bus.usb_store | io_bus.usb_get;
`ifdef RR_ARB_EN
    if (r_ahb_wait == WAIT_LIMIT)      w_ahb_prio = 1'b1;
    else if (r_usb_wait == WAIT_LIMIT) w_ahb_prio = 1'b0;
    else                               w_ahb_prio = r_last_usb;
`else
    w_ahb_prio = (r_ahb_wait == WAIT_LIMIT);
`endif
    // clear blocks both grants; the held request is re-arbitrated afterwards
    w_usb_win = !io_bus.clear && w_usb_req && !(w_ahb_req && w_ahb_prio);
    w_ahb_win = !io_bus.clear && w_ahb_req && !w_usb_win;
    // store dominates when a side illegally raises store and get together
    w_store   = w_usb_win ? io_bus.usb_store : (w_ahb_win & io_bus.ahb_store);
    w_get     = (w_usb_win | w_ahb_win) & !w_store;
    w_wdata   = w_usb_win ? io_bus.usb_wdata : io_bus.ahb_wdata;
    w_full    = (r_occ == OCC_FULL);
    w_empty   = (r_occ == '0);
    w_we      = w_store & !w_full;
    w_re      = w_get & !w_empty;
    if (io_bus.clear)   w_state_nxt = S_FLUSH;
    else if (w_usb_win) w_state_nxt = S_USB_ACC;
    else if (w_ahb_win) w_state_nxt = S_AHB_ACC;
    else                w_state_nxt = S_IDLE;
  end

  assign io_bus.ahb_grant        = w_ahb_win;
  assign io_bus.usb_grant        = w_usb_win;
  assign io_bus.mem_we           = w_we;
  assign io_bus.mem_re           = w_re;
  assign io_bus.mem_addr         = w_we ? r_wr_ptr : r_rd_ptr;
  assign io_bus.mem_wdata        = w_we ? w_wdata : 8'h00;
  // RAM data arrives the cycle after mem_re; an underflow get presents the zeroed hold value
  assign io_bus.rd_data          = r_rd_from_ram ? io_bus.mem_rdata : r_rd_hold;
  assign io_bus.ahb_rvalid       = r_got && (r_state == S_AHB_ACC);
  assign io_bus.usb_rvalid       = r_got && (r_state == S_USB_ACC);
  assign io_bus.buffer_occupancy = r_occ;
  assign io_bus.overflow_err     = r_ovf;
  assign io_bus.underflow_err    = r_unf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_occ         <= '0;
      r_ahb_wait    <= '0;
`ifdef RR_ARB_EN
      r_usb_wait    <= '0;
      r_last_usb    <= 1'b0;
`endif
      r_got         <= 1'b0;
      r_rd_from_ram <= 1'b0;
      r_rd_hold     <= 8'h00;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_got         <= w_get;
      r_rd_from_ram <= w_re;
      if (w_get && w_empty)  r_rd_hold <= 8'h00;
      else if (r_rd_from_ram) r_rd_hold <= io_bus.mem_rdata;

      if (io_bus.clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_occ      <= '0;
        r_ahb_wait <= '0;
`ifdef RR_ARB_EN
        r_usb_wait <= '0;
`endif
        r_ovf      <= 1'b0;
        r_unf      <= 1'b0;
      end else begin
        if (w_store) begin
          if (w_full) r_ovf <= 1'b1;
          else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_occ    <= r_occ + 1'b1;
          end
        end
        if (w_get) begin
          if (w_empty) r_unf <= 1'b1;
          else begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_occ    <= r_occ - 1'b1;
          end
        end
        if (w_ahb_win)      r_ahb_wait <= '0;
        else if (w_ahb_req) r_ahb_wait <= r_ahb_wait + 1'b1;
`ifdef RR_ARB_EN
        if (w_usb_win)      r_usb_wait <= '0;
        else if (w_usb_req) r_usb_wait <= r_usb_wait + 1'b1;
        if (w_ahb_req && w_usb_req) r_last_usb <= w_usb_win;
`endif
      end
    end
  end
endmodule

// File: tb/tb_data_buffer_arbiter.sv
// tb/tb_data_buffer_arbiter.sv - randomized and directed checks of data_buffer_arbiter against a FIFO model
module tb_data_buffer_arbiter;
  localparam int DEPTH    = 64;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_buffer_arbiter_if #(.PTR_W(6)) bus();

  data_buffer_arbiter #(.DEPTH(DEPTH), .PTR_W(6), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // reference model: byte queue plus access counts since the last flush
  byte unsigned q[$];
  int         m_wr, m_rd, m_aw, m_uw;
  bit         m_last_usb, m_ovf, m_unf, p_av, p_uv;
  logic [7:0] p_data;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_wr = 0; m_rd = 0; m_aw = 0; m_uw = 0;
    m_last_usb = 0; m_ovf = 0; m_unf = 0; p_av = 0; p_uv = 0; p_data = 8'h00;
  endtask

  task automatic set_in(input logic cl, input logic ast, input logic agt, input logic [7:0] awd,
                        input logic ust, input logic ugt, input logic [7:0] uwd);
    bus.clear = cl; bus.ahb_store = ast; bus.ahb_get = agt; bus.ahb_wdata = awd;
    bus.usb_store = ust; bus.usb_get = ugt; bus.usb_wdata = uwd;
  endtask

  // called just after a rising edge: predicts, checks mid-cycle, then advances the model
  task automatic step(output bit ag, output bit ug);
    bit a_req, u_req, st, op, ex_we, ex_re;
    logic [7:0] wd;
    #3;
    a_req = bus.ahb_store | bus.ahb_get;
    u_req = bus.usb_store | bus.usb_get;
    ag = 0; ug = 0;
    if (!bus.clear) begin
      if (a_req && u_req) begin
`ifdef RR_ARB_EN
        if (m_aw == MAX_WAIT)      ag = 1;
        else if (m_uw == MAX_WAIT) ug = 1;
        else if (m_last_usb)       ag = 1;
        else                       ug = 1;
`else
        if (m_aw == MAX_WAIT) ag = 1;
        else                  ug = 1;
`endif
      end else begin
        ag = a_req; ug = u_req;
      end
    end
    st    = ug ? bus.usb_store : (ag & bus.ahb_store);
    wd    = ug ? bus.usb_wdata : bus.ahb_wdata;
    op    = ag | ug;
    ex_we = op && st && (q.size() < DEPTH);
    ex_re = op && !st && (q.size() > 0);
    chk("ahb_grant", bus.ahb_grant, ag);
    chk("usb_grant", bus.usb_grant, ug);
    chk("mem_we", bus.mem_we, ex_we);
    chk("mem_re", bus.mem_re, ex_re);
    if (ex_we) begin
      chk("wr_addr", bus.mem_addr, m_wr);
      chk("mem_wdata", bus.mem_wdata, wd);
    end
    if (ex_re) chk("rd_addr", bus.mem_addr, m_rd);
    chk("ahb_rvalid", bus.ahb_rvalid, p_av);
    chk("usb_rvalid", bus.usb_rvalid, p_uv);
    if (p_av || p_uv) chk("rd_data", bus.rd_data, p_data);
    chk("occupancy", bus.buffer_occupancy, q.size());
    chk("overflow_err", bus.overflow_err, m_ovf);
    chk("underflow_err", bus.underflow_err, m_unf);
    @(posedge clk);
    #1;
    p_av = ag && !st;
    p_uv = ug && !st;
    if (bus.clear) begin
      q.delete();
      m_wr = 0; m_rd = 0; m_aw = 0; m_uw = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (op && st) begin
        if (q.size() == DEPTH) m_ovf = 1;
        else begin q.push_back(wd); m_wr = (m_wr + 1) % DEPTH; end
      end
      if (op && !st) begin
        if (q.size() == 0) begin m_unf = 1; p_data = 8'h00; end
        else begin p_data = q.pop_front(); m_rd = (m_rd + 1) % DEPTH; end
      end
      if (ag) m_aw = 0; else if (a_req) m_aw++;
      if (ug) m_uw = 0; else if (u_req) m_uw++;
      if (a_req && u_req) m_last_usb = ug;
    end
  endtask

  task automatic cyc(input logic cl, input logic ast, input logic agt, input logic [7:0] awd,
                     input logic ust, input logic ugt, input logic [7:0] uwd);
    bit ag, ug;
    set_in(cl, ast, agt, awd, ust, ugt, uwd);
    step(ag, ug);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  initial begin
    bit ag, ug, a_pend, u_pend, store_bias;
    int r;
    set_in(0, 0, 0, 8'h00, 0, 0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ahb_grant", bus.ahb_grant, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rvalid", {bus.ahb_rvalid, bus.usb_rvalid}, 0);
    chk("rst_mem", {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_occupancy", bus.buffer_occupancy, 0);
    chk("rst_errs", {bus.overflow_err, bus.underflow_err}, 0);
    rst = 1'b0;

    // USB stores three bytes, AHB reads them back
    cyc(0, 0, 0, 8'h00, 1, 0, 8'hA1);
    cyc(0, 0, 0, 8'h00, 1, 0, 8'hA2);
    cyc(0, 0, 0, 8'h00, 1, 0, 8'hA3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);
    idle(1);

    // fill, overflow, flush
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 0, 8'($urandom), 0, 0, 8'h00);
    idle(1);
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
    idle(1);

    // pointer wrap
    for (int i = 0; i < 60; i++) cyc(0, 1, 0, 8'($urandom), 0, 0, 8'h00);
    for (int i = 0; i < 60; i++) cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'($urandom), 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);
    idle(1);

    // contention: usb_store and ahb_get held together
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'h00, 1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);

    // underflow on empty
    cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);
    idle(1);

    // clear collides with a held usb_store
    cyc(1, 0, 0, 8'h00, 1, 0, 8'h77);
    cyc(0, 0, 0, 8'h00, 1, 0, 8'h77);
    idle(1);
    cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);
    idle(1);

    // randomized traffic with hold-until-grant requesters
    a_pend = 0; u_pend = 0; store_bias = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) store_bias = ~store_bias;
      if (!a_pend) begin
        r = $urandom_range(0, 3);
        bus.ahb_store = (r == 1) || (r == 3 && store_bias);
        bus.ahb_get   = (r == 2) || (r == 3 && !store_bias);
        bus.ahb_wdata = 8'($urandom);
      end
      if (!u_pend) begin
        r = $urandom_range(0, 3);
        bus.usb_store = (r == 1) || (r == 3 && store_bias);
        bus.usb_get   = (r == 2) || (r == 3 && !store_bias);
        bus.usb_wdata = 8'($urandom);
      end
      bus.clear = ($urandom_range(0, 99) == 0);
      a_pend = bus.ahb_store | bus.ahb_get;
      u_pend = bus.usb_store | bus.usb_get;
      step(ag, ug);
      if (ag) a_pend = 0;
      if (ug) u_pend = 0;
    end
    idle(1);
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);

    // reset while a read return is in flight
    cyc(0, 1, 0, 8'h5A, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h00, 0, 0, 8'h00);
    set_in(0, 0, 0, 8'h00, 0, 0, 8'h00);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", bus.ahb_rvalid, 0);
    chk("midrst_occupancy", bus.buffer_occupancy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
